// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector.
// Shifts in one bit per qualified clock and pulses `match` for one cycle when
// the most recent len bits equal the active pattern. Overlap mode, pattern and
// length are run-time loadable; a saturating hit counter tracks matches.
module seq_detector_param #(
    parameter int                   MAX_LEN = 8,
    parameter logic [MAX_LEN-1:0]   PATTERN = 8'b0001_1001,
    parameter int                   PAT_LEN = 5,
    parameter bit                   OVERLAP = 1'b0,
    parameter int                   CNT_W   = 16,
    parameter int                   LW      = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                din,
    input  logic                din_vld,
    input  logic                cfg_ld,
    input  logic [MAX_LEN-1:0]  pat_in,
    input  logic [LW-1:0]       len_in,
    input  logic                ovl_in,
    input  logic                cnt_clr,
    output logic                match,
    output logic [CNT_W-1:0]    match_cnt,
    output logic                cfg_err
);

    // Reset-time configuration is invalid for a zero or oversized length.
    localparam logic RST_ERR = (PAT_LEN == 0) || (PAT_LEN > MAX_LEN);

    // Active configuration
    logic [MAX_LEN-1:0] pat_r;
    logic [LW-1:0]      len_r;
    logic               ovl_r;

    // Detection state
    logic [MAX_LEN-1:0] hist_r;
    logic [LW-1:0]      fill_r;
    logic               match_r;
    logic [CNT_W-1:0]   match_cnt_r;
    logic               cfg_err_r;

    // Next-state helpers
    logic [MAX_LEN-1:0] hist_n_s;
    logic [LW-1:0]      fill_n_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               accept_s;
    logic               hit_s;
    logic               cfg_err_n_s;

    // Compute the shifted history, fill level, length mask and hit decision.
    always_comb begin
        hist_n_s    = {hist_r[MAX_LEN-2:0], din};
        fill_n_s    = len_r;
        mask_s      = {MAX_LEN{1'b0}};
        accept_s    = din_vld && !cfg_ld && !cfg_err_r;
        hit_s       = 1'b0;
        cfg_err_n_s = (len_in == {LW{1'b0}}) || (len_in > LW'(MAX_LEN));

        if (fill_r < len_r) begin
            fill_n_s = fill_r + LW'(1);
        end else begin
            fill_n_s = len_r;
        end

        // Only the low len_r bits take part in the compare.
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (LW'(i) < len_r);
        end

        if (accept_s && (fill_n_s == len_r) &&
            (((hist_n_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}})) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Configuration, history, fill level, hit pulse and saturating counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_r       <= PATTERN;
            len_r       <= LW'(PAT_LEN);
            ovl_r       <= OVERLAP;
            hist_r      <= {MAX_LEN{1'b0}};
            fill_r      <= {LW{1'b0}};
            match_r     <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
            cfg_err_r   <= RST_ERR;
        end else begin
            if (cfg_ld) begin
                // A load wins over a valid bit; that bit is dropped.
                pat_r     <= pat_in;
                len_r     <= len_in;
                ovl_r     <= ovl_in;
                hist_r    <= {MAX_LEN{1'b0}};
                fill_r    <= {LW{1'b0}};
                match_r   <= 1'b0;
                cfg_err_r <= cfg_err_n_s;
            end else if (accept_s) begin
                hist_r  <= hist_n_s;
                match_r <= hit_s;
                // Non-overlap mode restarts the fill so no matched bit is reused.
                if (hit_s && !ovl_r) begin
                    fill_r <= {LW{1'b0}};
                end else begin
                    fill_r <= fill_n_s;
                end
            end else begin
                match_r <= 1'b0;
            end

            // Clear wins over an increment; the pulse itself is unaffected.
            if (cnt_clr) begin
                match_cnt_r <= {CNT_W{1'b0}};
            end else if (hit_s && (match_cnt_r != {CNT_W{1'b1}})) begin
                match_cnt_r <= match_cnt_r + CNT_W'(1);
            end else begin
                match_cnt_r <= match_cnt_r;
            end
        end
    end

    assign match     = match_r;
    assign match_cnt = match_cnt_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param.
// Two instances share stimulus: a default one (16-bit counter) and one with a
// 2-bit counter to observe saturation.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               reset;
    logic               din;
    logic               din_vld;
    logic               cfg_ld;
    logic [MAX_LEN-1:0] pat_in;
    logic [LW-1:0]      len_in;
    logic               ovl_in;
    logic               cnt_clr;

    logic               match;
    logic [15:0]        match_cnt;
    logic               cfg_err;
    logic               match2;
    logic [1:0]         match_cnt2;
    logic               cfg_err2;

    int n_checks;
    int n_fails;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .PATTERN (8'b0001_1001),
        .PAT_LEN (5),
        .OVERLAP (1'b0),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_vld   (din_vld),
        .cfg_ld    (cfg_ld),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .ovl_in    (ovl_in),
        .cnt_clr   (cnt_clr),
        .match     (match),
        .match_cnt (match_cnt),
        .cfg_err   (cfg_err)
    );

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .PATTERN (8'b0001_1001),
        .PAT_LEN (5),
        .OVERLAP (1'b0),
        .CNT_W   (2)
    ) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_vld   (din_vld),
        .cfg_ld    (cfg_ld),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .ovl_in    (ovl_in),
        .cnt_clr   (cnt_clr),
        .match     (match2),
        .match_cnt (match_cnt2),
        .cfg_err   (cfg_err2)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given valid/data; returns 1 ns after the edge.
    task automatic step(input logic v, input logic b);
        din_vld = v;
        din     = b;
        @(posedge clk);
        #1;
    endtask

    // Send n bits (bit n-1 first) and check match after each against exp.
    task automatic send_seq(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i]);
            check_eq(tag, {31'd0, match}, {31'd0, exp[i]});
        end
        din_vld = 1'b0;
    endtask

    // Same as send_seq but with an idle cycle after every bit.
    task automatic send_gapped(input string tag, input logic [15:0] bits, input int n,
                               input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i]);
            check_eq(tag, {31'd0, match}, {31'd0, exp[i]});
            step(1'b0, 1'b0);
            check_eq({tag, "_gap"}, {31'd0, match}, 32'd0);
        end
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic o);
        cfg_ld = 1'b1;
        pat_in = p;
        len_in = l;
        ovl_in = o;
        step(1'b0, 1'b0);
        cfg_ld = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        din      = 1'b0;
        din_vld  = 1'b0;
        cfg_ld   = 1'b0;
        pat_in   = 8'd0;
        len_in   = 4'd0;
        ovl_in   = 1'b0;
        cnt_clr  = 1'b0;

        // Reset state
        #12;
        check_eq("rst_match", {31'd0, match}, 32'd0);
        check_eq("rst_cnt", {16'd0, match_cnt}, 32'd0);
        check_eq("rst_err", {31'd0, cfg_err}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Default pattern 11001, one-cycle pulse
        send_seq("dflt", 16'b11001, 5, 16'b00001);
        check_eq("dflt_cnt", {16'd0, match_cnt}, 32'd1);
        step(1'b0, 1'b0);
        check_eq("dflt_pulse_end", {31'd0, match}, 32'd0);

        // Non-overlap stream 110011001: one hit
        send_seq("novl", 16'b110011001, 9, 16'b000010000);
        check_eq("novl_cnt", {16'd0, match_cnt}, 32'd2);

        // Overlap stream 110011001: hits at bits 5 and 9
        load_cfg(8'b0001_1001, 4'd5, 1'b1);
        check_eq("ld_match", {31'd0, match}, 32'd0);
        send_seq("ovl", 16'b110011001, 9, 16'b000010001);
        check_eq("ovl_cnt", {16'd0, match_cnt}, 32'd4);
        check_eq("sat_cnt_a", {30'd0, match_cnt2}, 32'd3);

        // Short pattern 101, overlap then non-overlap
        load_cfg(8'b0000_0101, 4'd3, 1'b1);
        send_seq("p101_ovl", 16'b10101, 5, 16'b00101);
        load_cfg(8'b0000_0101, 4'd3, 1'b0);
        send_seq("p101_novl", 16'b10101, 5, 16'b00100);
        check_eq("p101_cnt", {16'd0, match_cnt}, 32'd7);

        // Back-to-back: pattern 11 on 111 in overlap mode
        load_cfg(8'b0000_0011, 4'd2, 1'b1);
        send_seq("b2b", 16'b111, 3, 16'b011);
        check_eq("b2b_cnt", {16'd0, match_cnt}, 32'd9);

        // Gaps in din_vld are invisible
        load_cfg(8'b0001_1001, 4'd5, 1'b0);
        send_gapped("gap", 16'b11001, 5, 16'b00001);
        check_eq("gap_cnt", {16'd0, match_cnt}, 32'd10);

        // cfg_ld on the completing edge discards the bit
        send_seq("ldpri_pre", 16'b1100, 4, 16'b0000);
        cfg_ld = 1'b1;
        pat_in = 8'b0001_1001;
        len_in = 4'd5;
        ovl_in = 1'b0;
        step(1'b1, 1'b1);
        cfg_ld = 1'b0;
        check_eq("ldpri_match", {31'd0, match}, 32'd0);
        check_eq("ldpri_cnt", {16'd0, match_cnt}, 32'd10);
        send_seq("ldpri_post", 16'b1, 1, 16'b0);

        // cnt_clr on a hit edge: pulse still seen, count cleared
        load_cfg(8'b0001_1001, 4'd5, 1'b0);
        send_seq("clr_pre", 16'b1100, 4, 16'b0000);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        din_vld = 1'b0;
        check_eq("clr_match", {31'd0, match}, 32'd1);
        check_eq("clr_cnt", {16'd0, match_cnt}, 32'd0);
        check_eq("clr_cnt_sat", {30'd0, match_cnt2}, 32'd0);

        // Invalid lengths disable detection
        load_cfg(8'b0001_1001, 4'd0, 1'b0);
        check_eq("err_len0", {31'd0, cfg_err}, 32'd1);
        send_seq("err_stream", 16'b11001, 5, 16'b00000);
        check_eq("err_cnt", {16'd0, match_cnt}, 32'd0);
        load_cfg(8'b0001_1001, 4'd9, 1'b0);
        check_eq("err_len9", {31'd0, cfg_err}, 32'd1);
        load_cfg(8'b1001_1001, 4'd8, 1'b0);
        check_eq("err_len8", {31'd0, cfg_err}, 32'd0);

        // Saturation: pattern 11 overlapped on six ones gives 5 hits
        load_cfg(8'b0000_0011, 4'd2, 1'b1);
        send_seq("sat", 16'b111111, 6, 16'b011111);
        check_eq("sat_cnt16", {16'd0, match_cnt}, 32'd5);
        check_eq("sat_cnt2", {30'd0, match_cnt2}, 32'd3);

        // Async reset while match is high clears outputs before the next edge
        load_cfg(8'b0001_1001, 4'd5, 1'b0);
        send_seq("ar_hit", 16'b11001, 5, 16'b00001);
        #2;
        reset = 1'b0;
        #1;
        check_eq("ar_match", {31'd0, match}, 32'd0);
        check_eq("ar_cnt", {16'd0, match_cnt}, 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Async reset mid-pattern: partial 1100 never completes
        send_seq("ar_part", 16'b1100, 4, 16'b0000);
        #3;
        reset = 1'b0;
        #1;
        check_eq("ar2_match", {31'd0, match}, 32'd0);
        check_eq("ar2_err", {31'd0, cfg_err}, 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_seq("ar_single", 16'b1, 1, 16'b0);
        load_cfg(8'b0001_1001, 4'd5, 1'b0);
        send_seq("ar_full", 16'b11001, 5, 16'b00001);
        check_eq("ar_full_cnt", {16'd0, match_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
